ch_config_writer: RTL and testbench

CH_CONFIG_WRITER -- requirements
Module: ch_config_writer

---
 rtl/ch_cfg_pkg.sv | 48 ++++
 rtl/ch_cfg_cmd_fifo.sv | 80 ++++++++
 rtl/ch_config_writer.sv | 140 ++++++++++++++
 tb/tb_ch_config_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ch_cfg_pkg.sv
// Shared types and constants for the channel configuration writer.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package ch_cfg_pkg;

    // Byte-writer FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WRITE = 3'd2,
        ST_GAP   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // Channel register file byte addresses
    localparam logic [7:0] PN_ORDER     = 8'h00;
    localparam logic [7:0] BIT_RATE_B0  = 8'h01;
    localparam logic [7:0] EDGE_TIME    = 8'h05;
    localparam logic [7:0] AMPLITUDE_B0 = 8'h06;
    localparam logic [7:0] DC_OFFSET_B0 = 8'h08;

    // One queued command: base address, byte count minus one, payload
    typedef struct packed {
        logic [7:0]  addr;
        logic [1:0]  len;
        logic [31:0] data;
    } cmd_t;

    localparam int CMD_W = $bits(cmd_t);

    // Select payload byte idx (byte 0 is the least significant)
    function automatic logic [7:0] cmd_byte(input logic [31:0] data, input logic [1:0] idx);
        logic [7:0] b;
        case (idx)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        return b;
    endfunction

    // Target address of byte idx; wraps modulo 256
    function automatic logic [7:0] byte_addr(input logic [7:0] base, input logic [1:0] idx);
        return base + {6'b000000, idx};
    endfunction

endpackage

// File: rtl/ch_cfg_cmd_fifo.sv
// Command FIFO: DEPTH entries of WIDTH bits, read data registered on pop.
// Latency: an entry pushed at edge N is poppable from edge N+1; rd_dat valid after the pop edge.
// Backpressure: full is registered; pushes while full are ignored, pops while empty are ignored.
module ch_cfg_cmd_fifo
    import ch_cfg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             CLK_LOW,
    input  logic             reset_n,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             push;
    logic             pop;

    assign push = wr_vld && !full;
    assign pop  = rd_en && !empty;

    // Occupancy after this edge; push and pop together leave it unchanged
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + (AW+1)'(1);
        end else if (pop && !push) begin
            count_nxt = count - (AW+1)'(1);
        end
    end

    // Storage array; no reset needed since flags gate every read
    always_ff @(posedge CLK_LOW) begin
        if (push) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers, occupancy and registered flags; pointers wrap since DEPTH is a power of two
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(DEPTH));
            empty <= (count_nxt == '0);
        end
    end

    // Head entry captured on pop so the consumer sees it the following cycle
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            rd_dat <= '0;
        end else if (pop) begin
            rd_dat <= mem[rd_ptr];
        end
    end

endmodule

// File: rtl/ch_config_writer.sv
// Turns queued multi-byte register commands into LSB-first byte writes to the channel register file.
// Latency: first CH_CONFIG_WE in the cycle after edge N+3 for a command accepted at idle edge N.
// Backpressure: cmd_ready = !fifo_full; with CH_CFG_WR_GAP_EN defined a WE-low cycle separates bytes.
module ch_config_writer
    import ch_cfg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        CLK_LOW,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [7:0]  cmd_addr,
    input  logic [1:0]  cmd_len,
    input  logic [31:0] cmd_data,
    output logic        CH_CONFIG_WE,
    output logic [7:0]  CH_CONFIG_ADDR,
    output logic [7:0]  CH_CONFIG_DATA,
    output logic        busy,
    output logic        cmd_done
);

    // State entered after a non-final byte: a spacer cycle lets the
    // receiver's update flag drop between bytes of one command.
`ifdef CH_CFG_WR_GAP_EN
    localparam state_t AFTER_BYTE = ST_GAP;
`else
    localparam state_t AFTER_BYTE = ST_WRITE;
`endif

    state_t     state;
    state_t     state_nxt;
    cmd_t       fifo_wr;
    cmd_t       fifo_rd;
    cmd_t       cur;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       load_en;
    logic       idx_inc;
    logic       last_byte;
    logic       we_nxt;
    logic       done_nxt;
    logic [1:0] idx;

    assign fifo_wr   = '{addr: cmd_addr, len: cmd_len, data: cmd_data};
    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state != ST_IDLE);
    assign last_byte = (idx == cur.len);

    ch_cfg_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (CMD_W)
    ) u_cmd_fifo (
        .CLK_LOW (CLK_LOW),
        .reset_n (reset_n),
        .wr_vld  (cmd_valid),
        .wr_dat  (fifo_wr),
        .rd_en   (fifo_pop),
        .rd_dat  (fifo_rd),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // FSM state register
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD:  state_nxt = ST_WRITE;
            ST_WRITE: state_nxt = last_byte ? ST_DONE : AFTER_BYTE;
            ST_GAP:   state_nxt = ST_WRITE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: FIFO pop, command load, byte-index step, next WE and done
    always_comb begin
        fifo_pop = 1'b0;
        load_en  = 1'b0;
        idx_inc  = 1'b0;
        we_nxt   = 1'b0;
        done_nxt = 1'b0;
        case (state)
            ST_IDLE:  fifo_pop = !fifo_empty;
            ST_LOAD:  load_en  = 1'b1;
            ST_WRITE: begin
                we_nxt  = 1'b1;
                idx_inc = !last_byte;
            end
            ST_DONE:  done_nxt = 1'b1;
            default:  ;
        endcase
    end

    // Working copy of the active command and its byte index
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            cur <= '0;
            idx <= 2'd0;
        end else if (load_en) begin
            cur <= fifo_rd;
            idx <= 2'd0;
        end else if (idx_inc) begin
            idx <= idx + 2'd1;
        end
    end

    // Registered write port; address and data hold between writes
    always_ff @(posedge CLK_LOW or negedge reset_n) begin
        if (!reset_n) begin
            CH_CONFIG_WE   <= 1'b0;
            CH_CONFIG_ADDR <= 8'h00;
            CH_CONFIG_DATA <= 8'h00;
            cmd_done       <= 1'b0;
        end else begin
            CH_CONFIG_WE <= we_nxt;
            cmd_done     <= done_nxt;
            if (we_nxt) begin
                CH_CONFIG_ADDR <= byte_addr(cur.addr, idx);
                CH_CONFIG_DATA <= cmd_byte(cur.data, idx);
            end
        end
    end

endmodule

// File: tb/tb_ch_config_writer.sv
// Directed bench for ch_config_writer: reset, single/multi-byte, wrap, full FIFO, mid-command reset.
// Latency: checks first write at accept edge + 3 and cmd_done one cycle after the last write.
// Backpressure: fills the FIFO behind a busy writer and checks cmd_ready drops after four accepts.
module tb_ch_config_writer;
    import ch_cfg_pkg::*;

`ifdef CH_CFG_WR_GAP_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    logic        CLK_LOW = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [7:0]  cmd_addr = 8'h00;
    logic [1:0]  cmd_len = 2'd0;
    logic [31:0] cmd_data = 32'h0;
    logic        CH_CONFIG_WE;
    logic [7:0]  CH_CONFIG_ADDR;
    logic [7:0]  CH_CONFIG_DATA;
    logic        busy;
    logic        cmd_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    // Observed writes / done pulses and the expected write list
    logic [7:0] wq_a[$];
    logic [7:0] wq_d[$];
    int         wq_c[$];
    int         dq_c[$];
    logic [7:0] ea[$];
    logic [7:0] ed[$];

    ch_config_writer #(.FIFO_DEPTH(4)) dut (
        .CLK_LOW        (CLK_LOW),
        .reset_n        (reset_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_len        (cmd_len),
        .cmd_data       (cmd_data),
        .CH_CONFIG_WE   (CH_CONFIG_WE),
        .CH_CONFIG_ADDR (CH_CONFIG_ADDR),
        .CH_CONFIG_DATA (CH_CONFIG_DATA),
        .busy           (busy),
        .cmd_done       (cmd_done)
    );

    always #5 CLK_LOW = ~CLK_LOW;

    always @(posedge CLK_LOW) cyc <= cyc + 1;

    // Record every write strobe and done pulse mid-cycle
    always @(negedge CLK_LOW) begin
        if (reset_n && CH_CONFIG_WE) begin
            wq_a.push_back(CH_CONFIG_ADDR);
            wq_d.push_back(CH_CONFIG_DATA);
            wq_c.push_back(cyc);
        end
        if (reset_n && cmd_done) begin
            dq_c.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_obs();
        wq_a.delete(); wq_d.delete(); wq_c.delete(); dq_c.delete();
        ea.delete(); ed.delete();
    endtask

    task automatic expect_wr(input logic [7:0] a, input logic [7:0] d);
        ea.push_back(a);
        ed.push_back(d);
    endtask

    // Present one command and hold it until accepted; acc is the accept edge number
    task automatic send(input logic [7:0] a, input logic [1:0] l, input logic [31:0] d, output int acc);
        int n;
        n = 0;
        @(negedge CLK_LOW);
        cmd_valid = 1'b1;
        cmd_addr  = a;
        cmd_len   = l;
        cmd_data  = d;
        while (!cmd_ready && n < 200) begin
            @(negedge CLK_LOW);
            n++;
        end
        if (n >= 200) chk("rdy_tmo", {31'b0, cmd_ready}, 32'd1);
        @(posedge CLK_LOW);
        #1;
        acc = cyc;
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(negedge CLK_LOW);
            n++;
        end
        if (n >= 400) chk("drain_tmo", {31'b0, busy}, 32'd0);
        repeat (3) @(negedge CLK_LOW);
    endtask

    task automatic cmp_writes(input string tag);
        chk({tag, "_nwr"}, wq_a.size(), ea.size());
        for (int k = 0; k < ea.size() && k < wq_a.size(); k++) begin
            chk($sformatf("%s_a%0d", tag, k), {24'b0, wq_a[k]}, {24'b0, ea[k]});
            chk($sformatf("%s_d%0d", tag, k), {24'b0, wq_d[k]}, {24'b0, ed[k]});
        end
    endtask

    initial begin
        int acc;
        int n;

        // Reset state
        repeat (3) @(negedge CLK_LOW);
        chk("rst_we",   {31'b0, CH_CONFIG_WE}, 32'd0);
        chk("rst_addr", {24'b0, CH_CONFIG_ADDR}, 32'h00);
        chk("rst_data", {24'b0, CH_CONFIG_DATA}, 32'h00);
        chk("rst_done", {31'b0, cmd_done}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_rdy",  {31'b0, cmd_ready}, 32'd1);
        reset_n = 1'b1;
        repeat (2) @(negedge CLK_LOW);

        // PN order: single byte, latency from idle
        clear_obs();
        expect_wr(PN_ORDER, 8'h07);
        send(PN_ORDER, 2'd0, 32'h0000_0007, acc);
        chk("pn_busy", {31'b0, busy}, 32'd1);
        drain();
        cmp_writes("pn");
        if (wq_c.size() > 0) chk("pn_lat", wq_c[0], acc + 3);
        chk("pn_ndone", dq_c.size(), 1);
        if (dq_c.size() > 0 && wq_c.size() > 0) chk("pn_done_cyc", dq_c[0], wq_c[0] + 1);

        // Bit rate: four bytes LSB first, MSB write last
        clear_obs();
        expect_wr(8'h01, 8'h00); expect_wr(8'h02, 8'h00);
        expect_wr(8'h03, 8'h00); expect_wr(8'h04, 8'h02);
        send(BIT_RATE_B0, 2'd3, 32'h0200_0000, acc);
        drain();
        cmp_writes("br");
        if (wq_c.size() == 4) begin
            chk("br_lat", wq_c[0], acc + 3);
            for (int k = 0; k < 3; k++) chk($sformatf("br_step%0d", k), wq_c[k+1] - wq_c[k], STEP);
            chk("br_span", wq_c[3] - wq_c[0] + 1, 3 * STEP + 1);
            if (dq_c.size() > 0) chk("br_done_cyc", dq_c[0], wq_c[3] + 1);
        end
        chk("br_ndone", dq_c.size(), 1);

        // Address wrap past 0xFF
        clear_obs();
        expect_wr(8'hFE, 8'hAA); expect_wr(8'hFF, 8'hBB);
        expect_wr(8'h00, 8'hCC); expect_wr(8'h01, 8'hDD);
        send(8'hFE, 2'd3, 32'hDDCC_BBAA, acc);
        drain();
        cmp_writes("wrap");
        chk("wrap_hold_a", {24'b0, CH_CONFIG_ADDR}, 32'h01);

        // Full FIFO: writer busy with one command while five more arrive
        clear_obs();
        expect_wr(8'h05, 8'h0D); expect_wr(8'h06, 8'h0C);
        expect_wr(8'h07, 8'h0B); expect_wr(8'h08, 8'h0A);
        for (int k = 0; k < 5; k++) expect_wr(8'h20 + 8'(k), 8'h40 + 8'(k));
        send(EDGE_TIME, 2'd3, 32'h0A0B_0C0D, acc);
        for (int k = 0; k < 5; k++) begin
            send(8'h20 + 8'(k), 2'd0, 32'h40 + k, acc);
            if (k == 2) chk("fill_rdy3", {31'b0, cmd_ready}, 32'd1);
            if (k == 3) chk("full_rdy", {31'b0, cmd_ready}, 32'd0);
        end
        drain();
        cmp_writes("b2b");
        chk("b2b_ndone", dq_c.size(), 6);
        chk("b2b_rdy", {31'b0, cmd_ready}, 32'd1);

        // Reset after the second byte of a four-byte command
        clear_obs();
        send(AMPLITUDE_B0, 2'd3, 32'h4433_2211, acc);
        n = 0;
        while (wq_a.size() < 2 && n < 100) begin
            @(negedge CLK_LOW);
            #1;
            n++;
        end
        chk("mr_nwr2", wq_a.size(), 2);
        reset_n = 1'b0;
        #1;
        chk("mr_we",   {31'b0, CH_CONFIG_WE}, 32'd0);
        chk("mr_busy", {31'b0, busy}, 32'd0);
        chk("mr_rdy",  {31'b0, cmd_ready}, 32'd1);
        chk("mr_addr", {24'b0, CH_CONFIG_ADDR}, 32'h00);
        @(negedge CLK_LOW);
        reset_n = 1'b1;
        repeat (12) @(negedge CLK_LOW);
        chk("mr_nofurther", wq_a.size(), 2);
        chk("mr_ndone", dq_c.size(), 0);
        chk("mr_busy_after", {31'b0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
